// File: rtl/matrix_3x3_gen.sv
// matrix_3x3_gen: 3x3 pixel window builder over a raster stream with two line buffers.
module matrix_3x3_gen #(
  parameter int IMG_W = 640,
  parameter int IMG_H = 480,
  parameter int DW = 8
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          frame_sync,
  input  logic [DW-1:0] pix_in,
  input  logic          pix_en,
  output logic [DW-1:0] mat_p11,
  output logic [DW-1:0] mat_p12,
  output logic [DW-1:0] mat_p13,
  output logic [DW-1:0] mat_p21,
  output logic [DW-1:0] mat_p22,
  output logic [DW-1:0] mat_p23,
  output logic [DW-1:0] mat_p31,
  output logic [DW-1:0] mat_p32,
  output logic [DW-1:0] mat_p33,
  output logic          mat_en
);
  localparam int CW = $clog2(IMG_W);
  localparam int RW = $clog2(IMG_H);
  localparam logic [DW-1:0] Z = '0;
  logic [DW-1:0] lb1 [IMG_W];
  logic [DW-1:0] lb2 [IMG_W];
  logic [CW-1:0] col_q, col_d, col_cur;
  logic [RW-1:0] row_q, row_d, row_cur;
  logic [2:0][DW-1:0] top_q, top_d, mid_q, mid_d, bot_q, bot_d;
  logic en_q, en_d;
  logic col_end, row_end;
  // Each window row is stored already masked, so only the column taps need
  // masking as they shift in from the previous line's tail.
  function automatic logic [2:0][DW-1:0] shift(input logic [2:0][DW-1:0] w,
                                               input logic [DW-1:0] n,
                                               input logic [CW-1:0] c);
    return {n, c >= CW'(1) ? w[2] : Z, c >= CW'(2) ? w[1] : Z};
  endfunction
  always_comb begin
    col_cur = frame_sync ? '0 : col_q;
    row_cur = frame_sync ? '0 : row_q;
    col_end = col_cur == CW'(IMG_W - 1);
    row_end = row_cur == RW'(IMG_H - 1);
    col_d = !pix_en ? col_cur : col_end ? '0 : col_cur + CW'(1);
    row_d = !(pix_en && col_end) ? row_cur : row_end ? '0 : row_cur + RW'(1);
    top_d = pix_en ? shift(top_q, row_cur >= RW'(2) ? lb2[col_cur] : Z, col_cur) : top_q;
    mid_d = pix_en ? shift(mid_q, row_cur >= RW'(1) ? lb1[col_cur] : Z, col_cur) : mid_q;
    bot_d = pix_en ? shift(bot_q, pix_in, col_cur) : bot_q;
    en_d = pix_en;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      col_q <= '0;
      row_q <= '0;
      top_q <= '0;
      mid_q <= '0;
      bot_q <= '0;
      en_q <= 1'b0;
    end else begin
      col_q <= col_d;
      row_q <= row_d;
      top_q <= top_d;
      mid_q <= mid_d;
      bot_q <= bot_d;
      en_q <= en_d;
    end
  end
  always_ff @(posedge clk) begin
    if (pix_en && !rst) begin
      lb2[col_cur] <= lb1[col_cur];
      lb1[col_cur] <= pix_in;
    end
  end
  assign mat_p11 = top_q[0];
  assign mat_p12 = top_q[1];
  assign mat_p13 = top_q[2];
  assign mat_p21 = mid_q[0];
  assign mat_p22 = mid_q[1];
  assign mat_p23 = mid_q[2];
  assign mat_p31 = bot_q[0];
  assign mat_p32 = bot_q[1];
  assign mat_p33 = bot_q[2];
  assign mat_en = en_q;
endmodule

// File: tb/tb_matrix_3x3_gen.sv
// tb_matrix_3x3_gen: scoreboard bench comparing the window stream to an image-array model.
module tb_matrix_3x3_gen;
  localparam int W = 4;
  localparam int H = 4;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic frame_sync = 1'b0;
  logic pix_en = 1'b0;
  logic [7:0] pix_in = 8'h00;
  logic [7:0] p11, p12, p13, p21, p22, p23, p31, p32, p33;
  logic mat_en;
  logic [71:0] q[$];
  logic [7:0] img[H][W];
  int mr = 0, mc = 0;
  int total = 0, bad = 0;
  logic mon_on = 1'b0, en_prev = 1'b0, rst_prev = 1'b0;
  logic [71:0] last = '0;
  wire [71:0] win = {p11, p12, p13, p21, p22, p23, p31, p32, p33};
  always #5 clk = ~clk;
  matrix_3x3_gen #(.IMG_W(W), .IMG_H(H), .DW(8)) dut (
    .clk(clk), .rst(rst), .frame_sync(frame_sync), .pix_in(pix_in), .pix_en(pix_en),
    .mat_p11(p11), .mat_p12(p12), .mat_p13(p13),
    .mat_p21(p21), .mat_p22(p22), .mat_p23(p23),
    .mat_p31(p31), .mat_p32(p32), .mat_p33(p33),
    .mat_en(mat_en)
  );
  task automatic chk(input string nm, input logic [71:0] act, input logic [71:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask
  always @(posedge clk) begin
    en_prev <= pix_en;
    rst_prev <= rst;
  end
  always @(negedge clk) begin
    if (mon_on) begin
      if (rst_prev) last = '0;
      chk("mat_en", 72'(mat_en), 72'(en_prev && !rst_prev));
      if (en_prev && !rst_prev) begin
        if (q.size() == 0) begin
          total++;
          bad++;
          $display("FAIL unexpected_window: got %h want none", win);
        end else last = q.pop_front();
      end
      chk((en_prev && !rst_prev) ? "window" : "hold", win, last);
    end
  end
  // Expected window straight from image coordinates: tap (r-dr, c-dc) or zero off-image.
  task automatic send(input logic fs, input logic en, input logic [7:0] pix);
    logic [71:0] e;
    e = '0;
    if (fs) begin
      mr = 0;
      mc = 0;
    end
    if (en) begin
      img[mr][mc] = pix;
      for (int dr = 2; dr >= 0; dr--)
        for (int dc = 2; dc >= 0; dc--)
          e = {e[63:0], (mr >= dr && mc >= dc) ? img[mr-dr][mc-dc] : 8'h00};
      q.push_back(e);
      mc++;
      if (mc == W) begin
        mc = 0;
        mr++;
        if (mr == H) mr = 0;
      end
    end
    frame_sync = fs;
    pix_en = en;
    pix_in = pix;
    @(posedge clk);
    #1;
    frame_sync = 1'b0;
    pix_en = 1'b0;
  endtask
  task automatic do_reset();
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    mr = 0;
    mc = 0;
  endtask
  initial begin
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    mon_on = 1'b1;
    for (int i = 0; i < 16; i++) send(i == 0, 1'b1, 8'(16 * (i / 4) + i % 4));
    for (int i = 0; i < 16; i++) begin
      send(i == 0, 1'b1, 8'(16 * (i / 4) + i % 4));
      repeat (3) send(1'b0, 1'b0, 8'h00);
    end
    for (int i = 0; i < 16; i++) send(1'b0, 1'b1, 8'($urandom));
    for (int i = 0; i < 9; i++) send(i == 0, 1'b1, 8'(16 * (i / 4) + i % 4));
    do_reset();
    for (int i = 0; i < 16; i++) send(1'b0, 1'b1, 8'($urandom));
    for (int f = 0; f < 25; f++) begin
      for (int i = 0; i < 16; i++) begin
        send((i == 0 && $urandom_range(0, 1) == 1) || $urandom_range(0, 19) == 0,
             1'b1, 8'($urandom));
        repeat ($urandom_range(0, 3)) send($urandom_range(0, 9) == 0, 1'b0, 8'($urandom));
        if ($urandom_range(0, 59) == 0) do_reset();
      end
    end
    repeat (3) send(1'b0, 1'b0, 8'h00);
    chk("queue_empty", 72'(q.size()), 72'(0));
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
